// File: rtl/base_case_multiplier.sv
// ML-KEM NTT-domain base-case multiplier:
//   (a0 + a1*X) * (b0 + b1*X) mod (X^2 - zeta), coefficients mod Q.
//   c0 = a0*b0 + a1*b1*zeta, c1 = a0*b1 + a1*b0, both reduced to [0, Q-1].
// Two register stages (products, then reduction), one operand set per cycle.
// Build option: define BCM_KARATSUBA_EN to form the c1 cross term with one
// shared (a0+a1)*(b0+b1) product instead of two direct multipliers.
// Results are bit-identical in both builds.
module base_case_multiplier #(
  parameter int unsigned Q       = 3329,
  parameter int unsigned COEFF_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [COEFF_W-1:0] a0_i,
  input  logic [COEFF_W-1:0] a1_i,
  input  logic [COEFF_W-1:0] b0_i,
  input  logic [COEFF_W-1:0] b1_i,
  input  logic [COEFF_W-1:0] zeta_i,
  output logic [COEFF_W-1:0] c0_o,
  output logic [COEFF_W-1:0] c1_o,
  output logic               valid_o
);

  localparam int unsigned PROD_W  = 2 * COEFF_W;  // single coefficient product
  localparam int unsigned CROSS_W = PROD_W + 1;   // sum of two products
  localparam int unsigned RED_W   = PROD_W + 2;   // widest value fed to the reducer
`ifdef BCM_KARATSUBA_EN
  localparam int unsigned SUM_W   = COEFF_W + 1;  // a0+a1, b0+b1
  localparam int unsigned MID_W   = 2 * SUM_W;    // Karatsuba middle product
`endif

  // Barrett constant: with K = 36 and x < 2^26 the quotient estimate is at
  // most one short, so a single conditional subtract gives an exact result.
  localparam int unsigned     BARRETT_K = 36;
  localparam longint unsigned BARRETT_M = (64'd1 << BARRETT_K) / 64'(Q);

  // Exact x mod Q for any x < 2^RED_W.
  function automatic logic [COEFF_W-1:0] mod_q(input logic [RED_W-1:0] x);
    logic [63:0]      prod;
    logic [RED_W-1:0] quo;
    logic [RED_W-1:0] rem;
    prod = 64'(x) * BARRETT_M;
    quo  = RED_W'(prod >> BARRETT_K);
    rem  = x - RED_W'(quo * RED_W'(Q));
    if (rem >= RED_W'(Q)) begin
      rem = rem - RED_W'(Q);
    end
    return COEFF_W'(rem);
  endfunction

  // Stage-1 combinational products
  logic [PROD_W-1:0]  p00_c;
  logic [PROD_W-1:0]  p11_c;
  logic [CROSS_W-1:0] cross_c;
`ifdef BCM_KARATSUBA_EN
  logic [SUM_W-1:0]   sum_a_c;
  logic [SUM_W-1:0]   sum_b_c;
  logic [MID_W-1:0]   mid_c;
`endif

  // Stage-1 registers
  logic [PROD_W-1:0]  p00_q;
  logic [PROD_W-1:0]  p11_q;
  logic [CROSS_W-1:0] cross_q;
  logic [COEFF_W-1:0] zeta_q;
  logic               valid1_q;

  // Stage-2 combinational reduction
  logic [COEFF_W-1:0] p11_red_c;
  logic [RED_W-1:0]   c0_sum_c;
  logic [COEFF_W-1:0] c0_c;
  logic [COEFF_W-1:0] c1_c;

  // Form the partial products for c0 and the c1 cross term
  always_comb begin
    p00_c = PROD_W'(a0_i) * PROD_W'(b0_i);
    p11_c = PROD_W'(a1_i) * PROD_W'(b1_i);
`ifdef BCM_KARATSUBA_EN
    sum_a_c = SUM_W'(a0_i) + SUM_W'(a1_i);
    sum_b_c = SUM_W'(b0_i) + SUM_W'(b1_i);
    mid_c   = MID_W'(sum_a_c) * MID_W'(sum_b_c);
    // Middle product minus both diagonals is exactly a0*b1 + a1*b0 (never negative)
    cross_c = CROSS_W'(mid_c - MID_W'(p00_c) - MID_W'(p11_c));
`else
    cross_c = CROSS_W'(PROD_W'(a0_i) * PROD_W'(b1_i))
            + CROSS_W'(PROD_W'(a1_i) * PROD_W'(b0_i));
`endif
  end

  // Stage-1 pipeline register; data only moves when a valid set arrives
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid1_q <= 1'b0;
      p00_q    <= '0;
      p11_q    <= '0;
      cross_q  <= '0;
      zeta_q   <= '0;
    end else begin
      valid1_q <= valid_i;
      if (valid_i) begin
        p00_q   <= p00_c;
        p11_q   <= p11_c;
        cross_q <= cross_c;
        zeta_q  <= zeta_i;
      end
    end
  end

  // Reduce a1*b1 first so the zeta product stays within 24 bits, then fold in p00
  always_comb begin
    p11_red_c = mod_q(RED_W'(p11_q));
    c0_sum_c  = RED_W'(PROD_W'(p11_red_c) * PROD_W'(zeta_q)) + RED_W'(p00_q);
    c0_c      = mod_q(c0_sum_c);
    c1_c      = mod_q(RED_W'(cross_q));
  end

  // Output register; data holds whenever no valid set leaves stage 1
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_o <= 1'b0;
      c0_o    <= '0;
      c1_o    <= '0;
    end else begin
      valid_o <= valid1_q;
      if (valid1_q) begin
        c0_o <= c0_c;
        c1_o <= c1_c;
      end
    end
  end

endmodule

// File: tb/tb_base_case_multiplier.sv
// Scoreboard bench for base_case_multiplier: a driver pushes the expected
// result with its due cycle, a negedge monitor pops and compares.
module tb_base_case_multiplier;

  localparam int unsigned COEFF_W = 12;
  localparam int          QMOD    = 3329;
  localparam int          N_RAND  = 10000;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid_i;
  logic [COEFF_W-1:0] a0_i, a1_i, b0_i, b1_i, zeta_i;
  logic [COEFF_W-1:0] c0_o, c1_o;
  logic               valid_o;

  base_case_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .a0_i    (a0_i),
    .a1_i    (a1_i),
    .b0_i    (b0_i),
    .b1_i    (b1_i),
    .zeta_i  (zeta_i),
    .c0_o    (c0_o),
    .c1_o    (c1_o),
    .valid_o (valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [COEFF_W-1:0] c0;
    logic [COEFF_W-1:0] c1;
    int                 due;
  } exp_t;

  exp_t               sb[$];
  exp_t               cur;
  int                 cyc = 0;
  logic               rst_seen;
  int                 checks = 0;
  int                 errors = 0;
  int                 pulses = 0;
  logic [COEFF_W-1:0] hold_c0 = '0;
  logic [COEFF_W-1:0] hold_c1 = '0;

  // Golden model: plain modular arithmetic on the polynomial product
  function automatic logic [COEFF_W-1:0] model_c0(int a0, int a1, int b0, int b1, int z);
    longint v;
    v = longint'(a0) * b0 + longint'(a1) * b1 * z;
    return COEFF_W'(v % QMOD);
  endfunction

  function automatic logic [COEFF_W-1:0] model_c1(int a0, int a1, int b0, int b1);
    longint v;
    v = longint'(a0) * b1 + longint'(a1) * b0;
    return COEFF_W'(v % QMOD);
  endfunction

  // Cycle count and the reset value the DUT sampled at this edge
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // Monitor: every cycle expect either the scoreboard head, reset zeros, or held data
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (valid_o === 1'b1) pulses++;
      if (rst_seen === 1'b0) begin
        checks++;
        if (valid_o !== 1'b0 || c0_o !== '0 || c1_o !== '0) begin
          errors++;
          $display("FAIL reset_state cyc=%0d: got valid=%b c0=%0d c1=%0d, want 0 0 0",
                   cyc, valid_o, c0_o, c1_o);
        end
        hold_c0 = '0;
        hold_c1 = '0;
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
        cur = sb.pop_front();
        checks++;
        if (valid_o !== 1'b1 || c0_o !== cur.c0 || c1_o !== cur.c1) begin
          errors++;
          $display("FAIL result cyc=%0d: got valid=%b c0=%0d c1=%0d, want 1 %0d %0d",
                   cyc, valid_o, c0_o, c1_o, cur.c0, cur.c1);
        end
        hold_c0 = cur.c0;
        hold_c1 = cur.c1;
      end else begin
        checks++;
        if (valid_o !== 1'b0 || c0_o !== hold_c0 || c1_o !== hold_c1) begin
          errors++;
          $display("FAIL idle_hold cyc=%0d: got valid=%b c0=%0d c1=%0d, want 0 %0d %0d",
                   cyc, valid_o, c0_o, c1_o, hold_c0, hold_c1);
        end
      end
    end
  end

  // Drive one operand set in the next cycle, optionally registering its expected result
  task automatic issue(input int a0, input int a1, input int b0, input int b1, input int z,
                       input bit push, input int e0, input int e1);
    @(posedge clk);
    #1;
    valid_i = 1'b1;
    a0_i    = COEFF_W'(a0);
    a1_i    = COEFF_W'(a1);
    b0_i    = COEFF_W'(b0);
    b1_i    = COEFF_W'(b1);
    zeta_i  = COEFF_W'(z);
    if (push) sb.push_back('{COEFF_W'(e0), COEFF_W'(e1), cyc + 2});
  endtask

  task automatic issue_rand(input bit push);
    int a0, a1, b0, b1, z;
    a0 = int'($urandom_range(QMOD - 1, 0));
    a1 = int'($urandom_range(QMOD - 1, 0));
    b0 = int'($urandom_range(QMOD - 1, 0));
    b1 = int'($urandom_range(QMOD - 1, 0));
    z  = int'($urandom_range(QMOD - 1, 0));
    issue(a0, a1, b0, b1, z, push, int'(model_c0(a0, a1, b0, b1, z)),
          int'(model_c1(a0, a1, b0, b1)));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      valid_i = 1'b0;
    end
  endtask

  // Wait (bounded) until every expected result has been seen
  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d results still outstanding, want 0", tag, sb.size());
      sb.delete();
    end
  endtask

  // Directed vectors: a0 a1 b0 b1 zeta -> c0 c1
  int dir_tab[7][7] = '{
    '{0,    0,    0,    0,    0,    0,    0},
    '{1,    0,    1,    0,    100,  1,    0},
    '{0,    1,    0,    1,    50,   50,   0},
    '{3328, 3328, 3328, 3328, 1,    2,    2},
    '{3328, 3328, 3328, 3328, 10,   11,   2},
    '{100,  3328, 100,  3328, 3328, 12,   3129},
    '{3328, 1,    1,    3328, 17,   3311, 2}
  };

  int pulses_start;

  initial begin
    // Reset held 5 cycles with valid traffic that must be ignored
    rst = 1'b0;
    valid_i = 1'b1;
    a0_i = '0; a1_i = '0; b0_i = '0; b1_i = '0; zeta_i = '0;
    repeat (5) issue_rand(1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    valid_i = 1'b0;
    idle(3);

    // Single shots, isolated
    for (int i = 0; i < 7; i++) begin
      issue(dir_tab[i][0], dir_tab[i][1], dir_tab[i][2], dir_tab[i][3], dir_tab[i][4],
            1'b1, dir_tab[i][5], dir_tab[i][6]);
      idle(3);
    end
    drain("directed");

    // Same vectors back-to-back
    for (int i = 0; i < 7; i++)
      issue(dir_tab[i][0], dir_tab[i][1], dir_tab[i][2], dir_tab[i][3], dir_tab[i][4],
            1'b1, dir_tab[i][5], dir_tab[i][6]);
    idle(3);
    drain("directed_b2b");

    // Long back-to-back random stream
    pulses_start = pulses;
    for (int i = 0; i < N_RAND; i++) issue_rand(1'b1);
    idle(4);
    drain("random");
    checks++;
    if (pulses - pulses_start != N_RAND) begin
      errors++;
      $display("FAIL pulse_count: got %0d valid_o pulses, want %0d", pulses - pulses_start, N_RAND);
    end

    // Sparse random traffic with gaps
    for (int i = 0; i < 50; i++) begin
      issue_rand(1'b1);
      if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(3, 1)));
    end
    idle(3);
    drain("sparse");

    // Reset mid-stream: one set in stage 1 and one being sampled at the reset edge
    repeat (3) issue_rand(1'b1);
    issue_rand(1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid_i = 1'b1;
    a0_i = 12'd5; a1_i = 12'd6; b0_i = 12'd7; b1_i = 12'd8; zeta_i = 12'd9;
    while (sb.size() > 0 && sb[sb.size() - 1].due > cyc) void'(sb.pop_back());
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(3);
    for (int i = 0; i < 20; i++) issue_rand(1'b1);
    idle(4);
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout at cyc=%0d, want completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
